i2s_tx_serializer: RTL
======================

Name: i2s_tx_serializer

Overview:
Consumer side of the 32-bit transmit FIFO. Pops stereo sample words (left, then right) and shifts them out as a standard Philips I2S stream (SCK, WS, SD), acting as the bus master. Sits between the TX FIFO read port and the chip pins. Runs entirely in the system clock domain, so SCK is generated by a clock-enable divider rather than a separate clock.

Parameters:
CLK_DIV, 2, system clocks per SCK half-period (>=1); SCK period = 2*CLK_DIV clk
WORD_W, 32, bits per channel slot; also the FIFO data width

Ports:
clk  in  1  system clock; all logic on posedge
Rst  in  1  synchronous, active-high reset
EN  in  1  transmit enable
fifo_data  in  WORD_W  FIFO read data; valid the clk after fifo_rd
fifo_empty  in  1  FIFO EMPTY flag
fifo_rd  out  1  one-clk pop request to the FIFO
sck  out  1  I2S serial clock
ws  out  1  word select; 0 = left, 1 = right
sd  out  1  serial data, MSB first
underrun  out  1  one-clk pulse: a word slot was sent as zeros
busy  out  1  1 while in RUN or STOP

Behaviour:
- Interface: one clock (clk); reset Rst is synchronous and active-high.
- Reset values: sck=0, ws=0, sd=0, fifo_rd=0, underrun=0, busy=0. State=IDLE, hold_valid=0, shift=0, div_cnt=0, bit_cnt=0. Rst overrides everything, including mid-word; the held word is discarded.
- Divider: in RUN/STOP, div_cnt counts 0..CLK_DIV-1. At CLK_DIV-1 it wraps and sck toggles. A toggle from 1->0 is a "fall event". Everything on the pins changes only at fall events.
- Prefetch (all states except reset): if !hold_valid && !fifo_empty && !rd_pending, assert fifo_rd for exactly 1 clk and set rd_pending. On the next clk, hold<=fifo_data, hold_valid=1, rd_pending=0. fifo_rd is never asserted while fifo_empty=1.
- States:
  - IDLE: sck=0, busy=0. When EN && hold_valid: set ws=1, bit_cnt=WORD_W-1, shift=0, div_cnt=0, then go to RUN.
  - RUN, at each fall event:
    - bit_cnt==0: word=hold if hold_valid, else all zeros with underrun=1 for 1 clk. sd<=word[MSB], shift<=word<<1, hold_valid<=0.
    - otherwise: sd<=shift[MSB], shift<<=1.
    - bit_cnt==WORD_W-1: ws toggles at this same fall event, so WS changes together with the LSB, one SCK before the next MSB.
    - bit_cnt increments mod WORD_W.
    - If EN==0 when ws is 1 and bit_cnt==WORD_W-1, go to STOP instead (frame-aligned stop).
  - STOP: at the next rise event (sck 0->1), hold sck=0, sd=0, ws=0, then go to IDLE. A pending/held word is kept.
- First fall event after IDLE->RUN emits a filler 0 and drops ws to 0 (I2S one-bit delay). Left MSB follows on the next fall event.
- Latency: EN=1 with hold_valid -> first sck rise after CLK_DIV clk. Left MSB on sd at the 2nd fall event.
- Prefetch has WORD_W SCK periods to complete, so it never misses a slot while the FIFO is non-empty.
- EN toggled low then high within the same frame: the frame completes normally and no stop occurs.
- Underrun does not stop the stream. The slot goes out as zeros and ws keeps alternating.

Decomposition:
- Shared package i2s_pkg: WORD_W default, state enum {IDLE, RUN, STOP}, CLK_DIV default. The package is common with the FIFO and the receiver.
- One natural sub-module: i2s_sck_gen (divider producing sck, rise and fall strobes; inputs clk, Rst, run).

Test Plan:
- Reset: assert Rst 3 clk with EN=1 and FIFO non-empty -> all outputs 0 and no fifo_rd until Rst drops.
- One frame (CLK_DIV=2): FIFO holds 0xA5A50F0F, 0x80000001; EN=1 ->
  - ws low for 32 SCK, sd = A5A50F0F MSB-first, sampled on sck rise;
  - ws rises with the LSB (1);
  - right slot = 1 then 30 zeros then 1.
- Underrun: FIFO holds one word only ->
  - right slot all zeros;
  - underrun high exactly 1 clk at that slot's MSB fall event;
  - stream continues.
- Streaming: 8 words preloaded, EN held ->
  - exactly 8 fifo_rd pulses, none while fifo_empty=1;
  - 4 contiguous frames with no gaps;
  - ws period = 64 SCK.
- Stop: drop EN mid-left word -> right word finishes, then sck/ws/sd=0 and busy=0; remaining FIFO words stay unread except the one prefetch.
- Mid-word reset: Rst during bit 10 of the left slot -> next clk all outputs 0 and hold_valid=0; restart sends the next FIFO word, not the discarded one.

Source files
------------

// File: rtl/i2s_pkg.sv
// ============================================================================
// i2s_pkg -- shared I2S defaults and state encoding (TX FIFO, serializer, RX)
// Rev 1.0
// ============================================================================
`default_nettype none

package i2s_pkg;

  localparam int I2S_WORD_W  = 32;
  localparam int I2S_CLK_DIV = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } i2s_state_e;

endpackage

`default_nettype wire

// File: rtl/i2s_tx_serializer_if.sv
// ============================================================================
// i2s_tx_serializer_if -- FIFO read port plus I2S pins of the TX serializer
// Rev 1.0
// ============================================================================
`default_nettype none

interface i2s_tx_serializer_if #(
  parameter int WORD_W = 32
);

  logic              en;
  logic [WORD_W-1:0] fifo_data;
  logic              fifo_empty;
  logic              fifo_rd;
  logic              sck;
  logic              ws;
  logic              sd;
  logic              underrun;
  logic              busy;

  modport master (
    input  en, fifo_data, fifo_empty,
    output fifo_rd, sck, ws, sd, underrun, busy
  );

  modport slave (
    output en, fifo_data, fifo_empty,
    input  fifo_rd, sck, ws, sd, underrun, busy
  );

endinterface

`default_nettype wire

// File: rtl/i2s_sck_gen.sv
// ============================================================================
// i2s_sck_gen -- clock-enable divider producing SCK with rise/fall strobes
// Rev 1.0
// ============================================================================
`default_nettype none

module i2s_sck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic Rst,
  input  logic run_i,
  input  logic park_i,
  output logic sck_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt_q;
  logic          sck_q;
  logic          wrap;

  assign wrap   = run_i && (div_cnt_q == DIV_LAST);
  assign rise_o = wrap && !sck_q;
  assign fall_o = wrap &&  sck_q;
  assign sck_o  = sck_q;

  // park_i swallows the pending rise so SCK stays low while the stream halts
  always_ff @(posedge clk) begin
    if (Rst || !run_i) begin
      div_cnt_q <= '0;
      sck_q     <= 1'b0;
    end else if (wrap) begin
      div_cnt_q <= '0;
      sck_q     <= park_i ? 1'b0 : ~sck_q;
    end else begin
      div_cnt_q <= div_cnt_q + DW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/i2s_tx_serializer.sv
// ============================================================================
// i2s_tx_serializer -- pops stereo words from the TX FIFO, drives Philips I2S
// Rev 1.0
// ============================================================================
`default_nettype none

module i2s_tx_serializer
  import i2s_pkg::*;
#(
  parameter int CLK_DIV = I2S_CLK_DIV,
  parameter int WORD_W  = I2S_WORD_W
) (
  input  logic                clk,
  input  logic                Rst,
  i2s_tx_serializer_if.master bus
);

  localparam int            BW       = $clog2(WORD_W);
  localparam logic [BW-1:0] BIT_LAST = BW'(WORD_W - 1);

  i2s_state_e        state_q, state_d;
  logic              hold_valid_q, hold_valid_d;
  logic              rd_pending_q, rd_pending_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              ws_q, ws_d;
  logic              sd_q, sd_d;
  logic              underrun_q, underrun_d;
  logic [WORD_W-1:0] word;
  logic              fifo_rd;
  logic              sck, rise, fall;

  i2s_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk    (clk),
    .Rst    (Rst),
    .run_i  (state_q != IDLE),
    .park_i (state_q == STOP),
    .sck_o  (sck),
    .rise_o (rise),
    .fall_o (fall)
  );

  assign fifo_rd      = !Rst && !hold_valid_q && !rd_pending_q && !bus.fifo_empty;
  assign bus.fifo_rd  = fifo_rd;
  assign bus.sck      = sck;
  assign bus.ws       = ws_q;
  assign bus.sd       = sd_q;
  assign bus.underrun = underrun_q;
  assign bus.busy     = (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    hold_valid_d = hold_valid_q;
    rd_pending_d = rd_pending_q;
    hold_d       = hold_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    ws_d         = ws_q;
    sd_d         = sd_q;
    underrun_d   = 1'b0;
    word         = hold_valid_q ? hold_q : '0;

    if (fifo_rd) rd_pending_d = 1'b1;
    if (rd_pending_q) begin
      hold_d       = bus.fifo_data;
      hold_valid_d = 1'b1;
      rd_pending_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        // ws starts high so the first fall drops it and emits the I2S delay bit
        if (bus.en && hold_valid_q) begin
          ws_d      = 1'b1;
          bit_cnt_d = BIT_LAST;
          shift_d   = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (fall) begin
          if (bit_cnt_q == '0) begin
            sd_d    = word[WORD_W-1];
            shift_d = word << 1;
            if (hold_valid_q) hold_valid_d = 1'b0;
            else              underrun_d   = 1'b1;
          end else begin
            sd_d    = shift_q[WORD_W-1];
            shift_d = shift_q << 1;
          end
          if (bit_cnt_q == BIT_LAST) begin
            ws_d      = ~ws_q;
            bit_cnt_d = '0;
            if (!bus.en && ws_q) state_d = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      STOP: begin
        if (rise) begin
          ws_d    = 1'b0;
          sd_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q      <= IDLE;
      hold_valid_q <= 1'b0;
      rd_pending_q <= 1'b0;
      hold_q       <= '0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      ws_q         <= 1'b0;
      sd_q         <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_valid_q <= hold_valid_d;
      rd_pending_q <= rd_pending_d;
      hold_q       <= hold_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      ws_q         <= ws_d;
      sd_q         <= sd_d;
      underrun_q   <= underrun_d;
    end
  end

endmodule

`default_nettype wire
